// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants for uart_rx_oversampled and uart_tx
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with asynchronous active-high reset
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver; UART_RX_PARITY_EN adds even parity checking
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int STOP_TICKS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int S_W = max_int(1, $clog2(max_int(OVERSAMPLE, STOP_TICKS)));
   localparam int N_W = max_int(1, $clog2(DATA_BITS));

   localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICKS - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

   rx_state_t            state;
   logic [S_W-1:0]       s_cnt;
   logic [N_W-1:0]       n_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         s_cnt     <= '0;
         n_cnt     <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_done <= 1'b0;
         case (state)
            // Start detection is deliberately tick-independent; a coincident tick is dropped.
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == S_HALF) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s_cnt <= '0;
                        n_cnt <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt + S_W'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == S_BIT) begin
                     s_cnt <= '0;
                     shreg <= DATA_BITS'({rx_s, shreg} >> 1);
                     if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n_cnt <= n_cnt + N_W'(1);
                     end
                  end else begin
                     s_cnt <= s_cnt + S_W'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s_cnt == S_BIT) begin
                     par_bit <= rx_s;
                     s_cnt   <= '0;
                     state   <= STOP;
                  end else begin
                     s_cnt <= s_cnt + S_W'(1);
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s_cnt == S_STOP) begin
                     state     <= IDLE;
                     rx_data   <= shreg;
                     frame_err <= ~rx_s;
                     rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err <= (^shreg) ^ par_bit;
`endif
                  end else begin
                     s_cnt <= s_cnt + S_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled; honours UART_RX_PARITY_EN
module tb_uart_rx_oversampled;

   localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int     checks = 0;
   int     errors = 0;
   int     done_cnt = 0;
   longint cyc = 0;
   longint done_cyc[$];
   exp_t   sb[$];

   uart_rx_oversampled dut (
      .clk        (clk),
      .reset      (reset),
      .s_tick     (s_tick),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // baud counter with final value 3: one tick every 4 clk
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   initial begin : monitor
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (prev) check("done_width", 32'(rx_done), 32'd0);
         if (rx_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            check("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("rx_data", 32'(rx_data), 32'(e.d));
               check("frame_err", 32'(frame_err), 32'(e.fe));
`ifdef UART_RX_PARITY_EN
               check("parity_err", 32'(parity_err), 32'(e.pe));
`endif
            end
         end
         prev = rx_done;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par,
                             input int stop_clks);
      exp_t e;
      e.d  = d;
      e.fe = ~stop_bit;
      e.pe = (^d) ^ par;
      sb.push_back(e);
      rx = 1'b0;
      idle(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         idle(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      idle(BIT_CLKS);
`endif
      rx = stop_bit;
      idle(stop_clks);
      rx = 1'b1;
   endtask

   task automatic wait_dones(input int n);
      int k;
      k = 0;
      while (done_cnt < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", 32'(done_cnt >= n), 32'd1);
   endtask

   initial begin : stim
      rx    = 1'b1;
      reset = 1'b1;
      idle(3);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_rx_done", 32'(rx_done), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      reset = 1'b0;
      idle(BIT_CLKS);

      send_frame(8'hA5, 1'b1, 1'b0, BIT_CLKS);
      wait_dones(1);
      idle(128);
      check("basic_done_count", 32'(done_cnt), 32'd1);

      // 3-tick low glitch must be rejected at the half-bit sample
      rx = 1'b0;
      idle(12);
      rx = 1'b1;
      idle(128);
      check("glitch_done_count", 32'(done_cnt), 32'd1);
      check("glitch_rx_data", 32'(rx_data), 32'hA5);

      // stop bit held low for 10 ticks only, so the line is high again before the next start sample
      send_frame(8'h3C, 1'b0, 1'b0, 40);
      wait_dones(2);
      idle(160);
      check("ferr_held", 32'(frame_err), 32'd1);
      send_frame(8'h01, 1'b1, 1'b0, BIT_CLKS);
      wait_dones(3);
      idle(128);
      check("ferr_cleared", 32'(frame_err), 32'd0);

      send_frame(8'h00, 1'b1, 1'b0, BIT_CLKS);
      send_frame(8'hFF, 1'b1, 1'b0, BIT_CLKS);
      wait_dones(5);
      idle(128);
      if (done_cyc.size() >= 5)
         check("b2b_interval", 32'(done_cyc[4] - done_cyc[3]), 32'(FRAME_BITS * BIT_CLKS));
      else
         check("b2b_pulses", 32'(done_cyc.size()), 32'd5);

      // 0x55 aborted by reset in the middle of data bit 4
      rx = 1'b0;
      idle(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = (i % 2 == 0) ? 1'b1 : 1'b0;
         idle(BIT_CLKS);
      end
      rx = 1'b1;
      idle(32);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle(12 * BIT_CLKS);
      check("abort_rx_data", 32'(rx_data), 32'd0);
      check("abort_done_count", 32'(done_cnt), 32'd5);

      send_frame(8'h81, 1'b1, 1'b0, BIT_CLKS);
      wait_dones(6);
      idle(128);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS);
      wait_dones(7);
      idle(128);
      send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS);
      wait_dones(8);
      idle(128);
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receiver that turns the serial `rx` line into parallel bytes, paced by the one-cycle `s_tick` pulse from the baud-rate modulus counter. `s_tick` runs at OVERSAMPLE× the bit rate. The block sits directly downstream of that counter and upstream of the RX FIFO or register interface. It detects the start bit, samples every data bit at mid-bit and checks the stop bit.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; even, ≥4.
- `STOP_TICKS`, 16: ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_tick` in 1: oversample enable from the baud counter; one clk wide.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_data` out DATA_BITS: last received word; held until the next `rx_done`.
- `rx_done` out 1: one-clk pulse; `rx_data` and the error flags are valid while it is high.
- `frame_err` out 1: stop bit sampled low; updated only with `rx_done`.
- `parity_err` out 1: present only with UART_RX_PARITY_EN.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer resets to 1.
- Counters:
  - `s_cnt`: tick counter, width $clog2(max(OVERSAMPLE, STOP_TICKS)).
  - `n_cnt`: bit counter, width $clog2(DATA_BITS).
  - `s_cnt` and `n_cnt` advance only in cycles where `s_tick` = 1.
- IDLE:
  - On `rx_s` = 0, go to START with `s_cnt` = 0.
  - Start-bit detection does not wait for `s_tick`.
- START:
  - On a tick with `s_cnt` = OVERSAMPLE/2−1:
    - If `rx_s` = 0, go to DATA with `s_cnt` = 0 and `n_cnt` = 0.
    - If `rx_s` = 1, the start bit was a glitch: return to IDLE with no outputs.
  - Otherwise, increment `s_cnt`.
- DATA:
  - On a tick with `s_cnt` = OVERSAMPLE−1:
    - Clear `s_cnt`.
    - Shift the shift register right, loading `rx_s` into the MSB.
    - If `n_cnt` = DATA_BITS−1, go to PARITY (macro defined) or STOP (macro undefined). Otherwise, increment `n_cnt`.
  - Otherwise, increment `s_cnt`.
- PARITY (macro only):
  - On a tick with `s_cnt` = OVERSAMPLE−1, latch the parity bit, clear `s_cnt` and go to STOP.
- STOP:
  - On a tick with `s_cnt` = STOP_TICKS−1:
    - Return to IDLE.
    - Register the shift register into `rx_data`.
    - Set `frame_err` = ~`rx_s`.
    - Pulse `rx_done`.
- Reset values: state = IDLE; `s_cnt`, `n_cnt`, shift register, `rx_data` = 0; `rx_done` = 0; `frame_err` = 0; `parity_err` = 0.
- Reset mid-frame aborts the frame: no `rx_done` is generated and the previous `rx_data` is cleared to 0.
- A frame with a bad stop bit is still delivered, with `frame_err` = 1.
- A break condition (`rx` held low) produces repeated frames of all zeros with `frame_err` = 1, one per frame time.
- An `s_tick` that arrives in the same cycle as the start-bit detection is not counted.

## Timing
- Synchronizer latency: 2 clk from an `rx` edge to `rx_s`.
- `rx_done` rises in the clk after the final STOP tick. It is exactly one clk wide, even if `s_tick` is continuously high.
- Frame latency, counted in ticks from the start-bit detect to `rx_done`:
  - Without parity: OVERSAMPLE/2 + DATA_BITS·OVERSAMPLE + STOP_TICKS.
  - With parity: add OVERSAMPLE.
  - Defaults without parity: 8 + 128 + 16 = 152 ticks.
- The block is back in IDLE in the same cycle `rx_done` is high. A start bit on `rx_s` in that cycle is accepted. This allows back-to-back frames.
- The downstream consumer must capture `rx_data` within one frame time. There is no backpressure.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and the `parity_err` output.
  - Parity is even: `parity_err` = XOR of the data bits and the parity bit.
  - `parity_err` is registered with `rx_done` and held until the next `rx_done`.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state and no `parity_err` port.
  - Frame is start + DATA_BITS + stop.

## Structure
- Package `uart_pkg`:
  - State enum `rx_state_t`, with IDLE, START, DATA, PARITY, STOP.
  - Default constants `UART_OVERSAMPLE` = 16 and `UART_DATA_BITS` = 8.
  - The package is shared with the future `uart_tx`.
- Sub-module `sync_2ff`:
  - Generic two-flop synchronizer with the same `reset` polarity.
  - Instantiated once for `rx`.

## Test plan
- **Basic frame.** `s_tick` every 4 clk (baud counter final value 3). Send 0xA5 with a stop bit of 1. Expect `rx_data` = 8'hA5 and a single one-clk `rx_done` pulse with `frame_err` = 0.
- **Glitch rejection.** Drive `rx` low for 3 ticks, then high. Expect the FSM back in IDLE after tick 8, with no `rx_done` and `rx_data` unchanged.
- **Frame error.** Send 0x3C with the stop bit driven 0. Expect `rx_data` = 8'h3C, `rx_done` = 1 and `frame_err` = 1. The next good frame, 0x01, clears `frame_err` to 0.
- **Back-to-back frames.** Send 0x00 and 0xFF with no idle gap. Expect two `rx_done` pulses 160 ticks apart (10 bits × 16) with the correct data in order.
- **Reset mid-frame.** Send 0x55; assert `reset` during data bit 4 for 1 clk. Expect `rx_data` = 0, no `rx_done`, and a subsequent 0x81 received correctly.
- **Parity (macro defined).** Send 0x07 with parity bit 1. Expect `parity_err` = 0. The same frame with parity bit 0 gives `parity_err` = 1.
